// File: rtl/seven_segment_reader.sv
// seven_segment_reader: recovers per-digit BCD values from a multiplexed seven-segment bus
module seven_segment_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_i,
  input  logic [NUM_DIGITS-1:0]   an_i,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]   blank_o,
  output logic                    frame_valid_o,
  output logic                    pattern_err_o,
  output logic                    scan_err_o
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  typedef enum logic [1:0] {WAIT, SETTLE, CAPTURE, HOLD} state_t;
  state_t                  state, state_n;
  logic [6:0]              seg_m, s_seg;
  logic [NUM_DIGITS-1:0]   an_m, s_an, an_lat, an_lat_n;
  logic [IW-1:0]           idx, idx_n, enc;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic                    one_hot, multi, eval, cap;
  logic [3:0]              dec_val;
  logic                    dec_blank, dec_err;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_n;
  logic [NUM_DIGITS-1:0]   blank_sh, blank_sh_n, mask, mask_n;

  // two-flop synchronisers on the asynchronous display bus
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      seg_m <= '0;
      s_seg <= '0;
      an_m  <= '0;
      s_an  <= '0;
    end else begin
      seg_m <= seg_i;
      s_seg <= seg_m;
      an_m  <= an_i;
      s_an  <= an_m;
    end

  // classify the synced digit select and find the selected digit index
  always_comb begin
    one_hot = $countones(s_an) == 1;
    multi   = $countones(s_an) > 1;
    enc     = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (s_an[i]) enc = IW'(i);
  end

  // segment pattern to BCD value; blank and illegal patterns flagged
  always_comb begin
    dec_val   = 4'hF;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (s_seg)
      7'h7E: dec_val = 4'd0;
      7'h30: dec_val = 4'd1;
      7'h6D: dec_val = 4'd2;
      7'h79: dec_val = 4'd3;
      7'h33: dec_val = 4'd4;
      7'h5B: dec_val = 4'd5;
      7'h5F: dec_val = 4'd6;
      7'h70: dec_val = 4'd7;
      7'h7F: dec_val = 4'd8;
      7'h7B: dec_val = 4'd9;
      7'h00: begin
        dec_val   = 4'd0;
        dec_blank = 1'b1;
      end
      default: dec_err = 1'b1;
    endcase
  end

  // FSM state register with settle counter and latched digit select
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= WAIT;
      cnt    <= '0;
      an_lat <= '0;
      idx    <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      an_lat <= an_lat_n;
      idx    <= idx_n;
    end

  // next state: a select change re-enters the WAIT decision in the same cycle; multi-hot aborts
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    an_lat_n = an_lat;
    idx_n    = idx;
    eval     = 1'b0;
    cap      = 1'b0;
    case (state)
      WAIT:    eval = 1'b1;
      SETTLE:
        if (s_an != an_lat) eval = 1'b1;
        else if (cnt == CNT_W'(SETTLE_CYCLES - 1)) state_n = CAPTURE;
        else cnt_n = cnt + CNT_W'(1);
      CAPTURE: begin
        cap     = 1'b1;
        state_n = HOLD;
      end
      HOLD:    eval = s_an != an_lat;
      default: state_n = WAIT;
    endcase
    if (eval) begin
      state_n  = one_hot ? SETTLE : WAIT;
      an_lat_n = s_an;
      idx_n    = enc;
      cnt_n    = '0;
    end
    if (multi) begin
      state_n = WAIT;
      cap     = 1'b0;
    end
  end

  // shadow and mask as they would look after capturing the current digit
  always_comb begin
    shadow_n              = shadow;
    blank_sh_n            = blank_sh;
    shadow_n[4*idx +: 4]  = dec_val;
    blank_sh_n[idx]       = dec_blank;
    mask_n                = mask | (NUM_DIGITS'(1) << idx);
  end

  // capture into shadow; the capture completing the mask publishes the frame and restarts it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shadow        <= '0;
      blank_sh      <= '0;
      mask          <= '0;
      digits_o      <= '0;
      blank_o       <= '0;
      frame_valid_o <= 1'b0;
      pattern_err_o <= 1'b0;
      scan_err_o    <= 1'b0;
    end else begin
      frame_valid_o <= cap & (&mask_n);
      pattern_err_o <= cap & dec_err;
      scan_err_o    <= multi;
      if (cap) begin
        shadow   <= shadow_n;
        blank_sh <= blank_sh_n;
        mask     <= &mask_n ? '0 : mask_n;
        if (&mask_n) begin
          digits_o <= shadow_n;
          blank_o  <= blank_sh_n;
        end
      end
    end
endmodule

// File: tb/tb_seven_segment_reader.sv
// tb_seven_segment_reader: directed and random scans checked against a per-digit frame model
module tb_seven_segment_reader;
  localparam int ND = 4;
  localparam int ST = 4;
  typedef struct {
    int               c;
    logic [4*ND-1:0]  d;
    logic [ND-1:0]    b;
  } fr_t;
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [6:0]      seg_i = '0;
  logic [ND-1:0]   an_i = '0;
  logic [4*ND-1:0] digits_o;
  logic [ND-1:0]   blank_o;
  logic            frame_valid_o, pattern_err_o, scan_err_o;
  int checks = 0, errors = 0, cyc = 0;
  int perr_obs = 0, serr_obs = 0, perr_exp = 0, serr_exp = 0, vi = 0;
  fr_t obs_q[$], exp_q[$];
  logic [6:0]      pat [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
  logic [4*ND-1:0] sh_m = '0;
  logic [ND-1:0]   bl_m = '0, mask_m = '0, prev_an = '0;

  seven_segment_reader #(.NUM_DIGITS(ND), .SETTLE_CYCLES(ST), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .seg_i(seg_i), .an_i(an_i), .digits_o(digits_o),
    .blank_o(blank_o), .frame_valid_o(frame_valid_o), .pattern_err_o(pattern_err_o),
    .scan_err_o(scan_err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    fr_t f;
    if (frame_valid_o) begin
      f.c = cyc;
      f.d = digits_o;
      f.b = blank_o;
      obs_q.push_back(f);
    end
    if (pattern_err_o) perr_obs++;
    if (scan_err_o) serr_obs++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] ref_dec(input logic [6:0] p);
    for (int i = 0; i < 10; i++)
      if (pat[i] == p) return {2'b00, 4'(i)};
    return p == 7'h00 ? 6'b010000 : 6'b101111;
  endfunction

  task automatic hold(input logic [ND-1:0] an, input logic [6:0] sg, input int n);
    int start, d;
    logic [5:0] r;
    fr_t f;
    if (an == prev_an && an != '0) begin
      an_i = '0;
      @(negedge clk);
    end
    an_i = an;
    seg_i = sg;
    start = cyc + 1;
    if ($countones(an) > 1) serr_exp += n;
    else if ($countones(an) == 1 && n > ST) begin
      d = 0;
      for (int i = 0; i < ND; i++) if (an[i]) d = i;
      r = ref_dec(sg);
      sh_m[4*d +: 4] = r[3:0];
      bl_m[d] = r[4];
      if (r[5]) perr_exp++;
      mask_m[d] = 1'b1;
      if (&mask_m) begin
        f.c = start + 3 + ST;
        f.d = sh_m;
        f.b = bl_m;
        exp_q.push_back(f);
        mask_m = '0;
      end
    end
    prev_an = an;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_phase(input string tag);
    hold('0, 7'h00, 14);
    chk({tag, ".frames"}, obs_q.size(), exp_q.size());
    for (int i = vi; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({tag, ".cyc"}, obs_q[i].c, exp_q[i].c);
      chk({tag, ".digits"}, 32'(obs_q[i].d), 32'(exp_q[i].d));
      chk({tag, ".blank"}, 32'(obs_q[i].b), 32'(exp_q[i].b));
    end
    vi = exp_q.size();
    chk({tag, ".perr"}, perr_obs, perr_exp);
    chk({tag, ".serr"}, serr_obs, serr_exp);
  endtask

  initial begin
    logic [ND-1:0] v;
    logic [6:0] sg;
    int k, r;
    repeat (3) @(negedge clk);
    chk("rst.digits", 32'(digits_o), 0);
    chk("rst.blank", 32'(blank_o), 0);
    chk("rst.flags", {frame_valid_o, pattern_err_o, scan_err_o}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    hold(4'b0001, 7'h33, 8);
    hold(4'b0010, 7'h79, 8);
    hold(4'b0100, 7'h6D, 8);
    hold(4'b1000, 7'h30, 8);
    check_phase("scan");
    chk("scan.value", 32'(digits_o), 32'h1234);
    chk("scan.blankv", 32'(blank_o), 0);
    hold(4'b0001, 7'h5B, 8);
    hold(4'b0010, 7'h5F, 8);
    hold(4'b0100, 7'h70, 2);
    hold(4'b1000, 7'h7F, 8);
    check_phase("glitch");
    hold(4'b0100, 7'h70, 8);
    check_phase("glitch2");
    chk("glitch.value", 32'(digits_o), 32'h8765);
    hold(4'b0001, 7'h7B, 8);
    hold(4'b0010, 7'h30, 8);
    hold(4'b0100, 7'h01, 8);
    hold(4'b1000, 7'h6D, 8);
    check_phase("illegal");
    chk("illegal.value", 32'(digits_o), 32'h2F19);
    hold(4'b0001, 7'h7E, 8);
    hold(4'b0010, 7'h30, 8);
    hold(4'b0011, 7'h6D, 1);
    hold(4'b0100, 7'h6D, 8);
    hold(4'b1000, 7'h79, 8);
    check_phase("multi");
    chk("multi.value", 32'(digits_o), 32'h3210);
    for (int i = 0; i < 2; i++) begin
      hold(4'b0001, 7'h79, 8);
      hold(4'b0010, 7'h00, 8);
      hold(4'b0100, 7'h33, 8);
      hold(4'b1000, 7'h7F, 8);
    end
    check_phase("blank");
    chk("blank.value", 32'(digits_o), 32'h8403);
    chk("blank.mask", 32'(blank_o), 32'h2);
    hold(4'b0001, 7'h30, 8);
    hold(4'b0010, 7'h6D, 8);
    hold(4'b0100, 7'h79, 3);
    rst_n = 1'b0;
    an_i = '0;
    mask_m = '0;
    prev_an = '0;
    #1;
    chk("midrst.digits", 32'(digits_o), 0);
    chk("midrst.blank", 32'(blank_o), 0);
    chk("midrst.flags", {frame_valid_o, pattern_err_o, scan_err_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hold(4'b0100, 7'h5F, 8);
    hold(4'b1000, 7'h70, 8);
    hold(4'b0001, 7'h7B, 8);
    check_phase("postrst");
    hold(4'b0010, 7'h5B, 8);
    check_phase("postrst2");
    chk("postrst.value", 32'(digits_o), 32'h7659);
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 9);
      r = $urandom_range(0, 11);
      sg = r < 10 ? pat[r] : (r == 10 ? 7'h00 : 7'($urandom));
      if (k == 0) begin
        do v = ND'($urandom); while ($countones(v) < 2);
        hold(v, sg, $urandom_range(1, 3));
      end else begin
        v = ND'(1) << $urandom_range(0, ND - 1);
        hold(v, sg, k < 3 ? $urandom_range(1, ST) : $urandom_range(ST + 2, ST + 8));
      end
    end
    check_phase("random");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
